// File: rtl/csr_file_v2.sv
// csr_file_v2: control/status register file for the scalar core.
// Holds mode, exception and interrupt state, a SAVE scratch bank, a countdown
// timer and a free-running stable counter. Reads are combinational. Writes,
// exception commits and ertn commits take effect on the next clock edge.
module csr_file_v2 #(
    parameter int NUM_SAVE = 4,
    parameter int TIMER_W  = 32,
    parameter int HWI_W    = 8,
    parameter int CNT_W    = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [13:0]      rd_addr,
    output logic [31:0]      rd_data,
    input  logic             csr_wr_en,
    input  logic [13:0]      wr_addr,
    input  logic [31:0]      wr_data,
    input  logic [31:0]      wr_mask,
    input  logic             excp_flush,
    input  logic             ertn_flush,
    input  logic [31:0]      era_in,
    input  logic [5:0]       ecode_in,
    input  logic [8:0]       esubcode_in,
    input  logic             va_error,
    input  logic [31:0]      badv_in,
    input  logic [HWI_W-1:0] hw_int_in,
    input  logic             ipi_int_in,
    output logic             has_int,
    output logic [31:0]      eentry_out,
    output logic [31:0]      era_out,
    output logic [CNT_W-1:0] cnt_val,
    output logic [31:0]      tid_out
);

    localparam logic [13:0] A_CRMD   = 14'h0000;
    localparam logic [13:0] A_PRMD   = 14'h0001;
    localparam logic [13:0] A_ECFG   = 14'h0004;
    localparam logic [13:0] A_ESTAT  = 14'h0005;
    localparam logic [13:0] A_ERA    = 14'h0006;
    localparam logic [13:0] A_BADV   = 14'h0007;
    localparam logic [13:0] A_EENTRY = 14'h000c;
    localparam logic [13:0] A_SAVE0  = 14'h0030;
    localparam logic [13:0] A_TID    = 14'h0040;
    localparam logic [13:0] A_TCFG   = 14'h0041;
    localparam logic [13:0] A_TVAL   = 14'h0042;
    localparam logic [13:0] A_TICLR  = 14'h0044;

    // Writable-bit masks; bits outside a mask always hold 0.
    localparam logic [31:0] CRMD_WM    = 32'h0000_000F;
    localparam logic [31:0] PRMD_WM    = 32'h0000_0007;
    localparam logic [31:0] ECFG_WM    = 32'h0000_1BFF;
    localparam logic [31:0] EENTRY_WM  = 32'hFFFF_FFC0;
    localparam logic [31:0] TCFG_WMASK = 32'hFFFF_FFFF >> (32 - TIMER_W);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Masked merge of new data into an old register value.
    function automatic logic [31:0] mwr(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [31:0] bit_m);
        return (old_v & ~bit_m) | (new_v & bit_m);
    endfunction

    // Timer reload value {InitVal, 2'b00} taken from a TCFG value.
    function automatic logic [31:0] init_val(input logic [31:0] cfg);
        return cfg & TCFG_WMASK & 32'hFFFF_FFFC;
    endfunction

    logic [31:0]      crmd_q, crmd_d, prmd_q, prmd_d, ecfg_q, ecfg_d;
    logic [31:0]      era_q, era_d, badv_q, badv_d, eentry_q, eentry_d;
    logic [31:0]      tid_q, tid_d, tcfg_q, tcfg_d, tval_q, tval_d;
    logic [12:0]      is_q, is_d;
    logic [5:0]       ecode_q, ecode_d;
    logic [8:0]       esub_q, esub_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      save_q [NUM_SAVE];
    logic [31:0]      save_d [NUM_SAVE];
    logic [7:0]       hw_ext_s;
    logic             timer_fire_s;

    assign hw_ext_s = 8'(hw_int_in);

    // Combinational read port; unimplemented addresses and bits read 0.
    always_comb begin
        rd_data = 32'h0000_0000;
        case (rd_addr)
            A_CRMD:   rd_data = crmd_q;
            A_PRMD:   rd_data = prmd_q;
            A_ECFG:   rd_data = ecfg_q;
            A_ESTAT:  rd_data = {1'b0, esub_q, ecode_q, 3'b000, is_q};
            A_ERA:    rd_data = era_q;
            A_BADV:   rd_data = badv_q;
            A_EENTRY: rd_data = eentry_q;
            A_TID:    rd_data = tid_q;
            A_TCFG:   rd_data = tcfg_q;
            A_TVAL:   rd_data = tval_q;
            A_TICLR:  rd_data = 32'h0000_0000;
            default: begin
                for (int i = 0; i < NUM_SAVE; i++) begin
                    if (rd_addr == A_SAVE0 + 14'(i)) begin
                        rd_data = save_q[i];
                    end else begin
                        rd_data = rd_data;
                    end
                end
            end
        endcase
    end

    // Next-state: timer, interrupt sampling, then flush/write with flush priority.
    always_comb begin
        crmd_d       = crmd_q;
        prmd_d       = prmd_q;
        ecfg_d       = ecfg_q;
        era_d        = era_q;
        badv_d       = badv_q;
        eentry_d     = eentry_q;
        tid_d        = tid_q;
        tcfg_d       = tcfg_q;
        tval_d       = tval_q;
        is_d         = is_q;
        ecode_d      = ecode_q;
        esub_d       = esub_q;
        save_d       = save_q;
        timer_fire_s = 1'b0;
        cnt_d        = cnt_q + CNT_ONE;

        if (tcfg_q[0]) begin
            if (tval_q != 32'h0000_0000) begin
                tval_d = tval_q - 32'h0000_0001;
            end else begin
                timer_fire_s = 1'b1;
                if (tcfg_q[1]) begin
                    tval_d = init_val(tcfg_q);
                end else begin
                    tcfg_d[0] = 1'b0;
                end
            end
        end else begin
            tval_d = tval_q;
        end

        // Interrupt lines are level-sampled, never latched.
        is_d[9:2] = hw_ext_s;
        is_d[10]  = 1'b0;
        is_d[12]  = ipi_int_in;

        if (excp_flush) begin
            prmd_d   = {29'h0, crmd_q[2:0]};
            crmd_d   = {crmd_q[31:3], 3'b000};
            era_d    = era_in;
            ecode_d  = ecode_in;
            esub_d   = esubcode_in;
            if (va_error) begin
                badv_d = badv_in;
            end else begin
                badv_d = badv_q;
            end
        end else if (ertn_flush) begin
            crmd_d[2:0] = prmd_q[2:0];
        end else if (csr_wr_en) begin
            case (wr_addr)
                A_CRMD:   crmd_d   = mwr(crmd_q, wr_data, wr_mask & CRMD_WM);
                A_PRMD:   prmd_d   = mwr(prmd_q, wr_data, wr_mask & PRMD_WM);
                A_ECFG:   ecfg_d   = mwr(ecfg_q, wr_data, wr_mask & ECFG_WM);
                A_ESTAT:  is_d[1:0] = (is_q[1:0] & ~wr_mask[1:0]) | (wr_data[1:0] & wr_mask[1:0]);
                A_ERA:    era_d    = mwr(era_q, wr_data, wr_mask);
                A_BADV:   badv_d   = mwr(badv_q, wr_data, wr_mask);
                A_EENTRY: eentry_d = mwr(eentry_q, wr_data, wr_mask & EENTRY_WM);
                A_TID:    tid_d    = mwr(tid_q, wr_data, wr_mask);
                A_TCFG: begin
                    // A TCFG write overrides any same-cycle hardware En clear.
                    tcfg_d = mwr(tcfg_q, wr_data, wr_mask & TCFG_WMASK);
                    tval_d = init_val(tcfg_d);
                end
                A_TICLR: begin
                    if (wr_data[0] & wr_mask[0]) begin
                        is_d[11] = 1'b0;
                    end else begin
                        is_d[11] = is_q[11];
                    end
                end
                default: begin
                    for (int i = 0; i < NUM_SAVE; i++) begin
                        if (wr_addr == A_SAVE0 + 14'(i)) begin
                            save_d[i] = mwr(save_q[i], wr_data, wr_mask);
                        end else begin
                            save_d[i] = save_d[i];
                        end
                    end
                end
            endcase
        end else begin
            crmd_d = crmd_d;
        end

        // Timer expiry beats a same-cycle TICLR clear.
        if (timer_fire_s) begin
            is_d[11] = 1'b1;
        end else begin
            is_d[11] = is_d[11];
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            crmd_q   <= 32'h0000_0008;
            prmd_q   <= 32'h0000_0000;
            ecfg_q   <= 32'h0000_0000;
            era_q    <= 32'h0000_0000;
            badv_q   <= 32'h0000_0000;
            eentry_q <= 32'h0000_0000;
            tid_q    <= 32'h0000_0000;
            tcfg_q   <= 32'h0000_0000;
            tval_q   <= 32'h0000_0000;
            is_q     <= 13'h0000;
            ecode_q  <= 6'h00;
            esub_q   <= 9'h000;
            cnt_q    <= {CNT_W{1'b0}};
            for (int i = 0; i < NUM_SAVE; i++) begin
                save_q[i] <= 32'h0000_0000;
            end
        end else begin
            crmd_q   <= crmd_d;
            prmd_q   <= prmd_d;
            ecfg_q   <= ecfg_d;
            era_q    <= era_d;
            badv_q   <= badv_d;
            eentry_q <= eentry_d;
            tid_q    <= tid_d;
            tcfg_q   <= tcfg_d;
            tval_q   <= tval_d;
            is_q     <= is_d;
            ecode_q  <= ecode_d;
            esub_q   <= esub_d;
            cnt_q    <= cnt_d;
            for (int i = 0; i < NUM_SAVE; i++) begin
                save_q[i] <= save_d[i];
            end
        end
    end

    assign has_int    = crmd_q[2] & (|(is_q & ecfg_q[12:0]));
    assign eentry_out = eentry_q;
    assign era_out    = era_q;
    assign cnt_val    = cnt_q;
    assign tid_out    = tid_q;

endmodule
